// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared state encodings and AXI response codes for the SDRAM arbiter
// Purpose: FSM state types for the read/write channel sequencers and AXI resp codes.
// Ports: none (package).
package axi_arb_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/axi_rr_arb2.sv
// rtl/axi_rr_arb2.sv - two-way arbiter with registered grant and round-robin pointer
// Purpose: picks one of two requesters when i_capture is high; the pointer decides ties.
// Ports:
//   clock, reset      - clock, synchronous active-high reset
//   i_req0, i_req1    - request lines of master 0 / master 1
//   i_capture         - channel idle: latch a new grant if anyone requests
//   i_done            - burst complete: advance the pointer
//   o_grant           - registered grant index (0 = master 0, 1 = master 1)
module axi_rr_arb2 #(
  parameter int RR_EN = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_capture,
  input  logic i_done,
  output logic o_grant
);

  logic r_grant;
  logic r_ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_grant <= 1'b0;
      r_ptr   <= 1'b0;
    end else begin
      // A lone requester always wins; only a tie consults the pointer.
      if (i_capture && (i_req0 || i_req1))
        r_grant <= (i_req0 && i_req1) ? r_ptr : i_req1;
      // Pointer favours the master that was just not served; pinned to s0 when fixed.
      if (i_done)
        r_ptr <= (RR_EN != 0) ? ~r_grant : 1'b0;
    end
  end

  assign o_grant = r_grant;

endmodule

// File: rtl/axi_sdram_arbiter.sv
// rtl/axi_sdram_arbiter.sv - two-master to one-slave AXI4 arbiter in front of the SDRAM port
// Purpose: s0 (instruction fetch) and s1 (load/store) share one AXI4 slave. Read and
//   write channels are arbitrated independently, one burst outstanding per direction.
//   Datapath muxing is combinational off the registered grant; the only added latency
//   is the idle-to-address cycle per burst.
// Ports:
//   clock, reset          - clock, synchronous active-high reset
//   s0_* / s1_*           - AXI4 slave-side ports of the two masters (AW, W, B, AR, R)
//   out_*                 - AXI4 master-side port towards the SDRAM in_* port
module axi_sdram_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int RR_EN  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  // s0
  input  logic                  s0_awvalid,
  output logic                  s0_awready,
  input  logic [ADDR_W-1:0]     s0_awaddr,
  input  logic [ID_W-1:0]       s0_awid,
  input  logic [7:0]            s0_awlen,
  input  logic [2:0]            s0_awsize,
  input  logic [1:0]            s0_awburst,
  input  logic                  s0_awlock,
  input  logic [3:0]            s0_awcache,
  input  logic [2:0]            s0_awprot,
  input  logic [3:0]            s0_awqos,
  input  logic                  s0_wvalid,
  output logic                  s0_wready,
  input  logic [DATA_W-1:0]     s0_wdata,
  input  logic [DATA_W/8-1:0]   s0_wstrb,
  input  logic                  s0_wlast,
  output logic                  s0_bvalid,
  input  logic                  s0_bready,
  output logic [1:0]            s0_bresp,
  output logic [ID_W-1:0]       s0_bid,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  input  logic [ADDR_W-1:0]     s0_araddr,
  input  logic [ID_W-1:0]       s0_arid,
  input  logic [7:0]            s0_arlen,
  input  logic [2:0]            s0_arsize,
  input  logic [1:0]            s0_arburst,
  input  logic                  s0_arlock,
  input  logic [3:0]            s0_arcache,
  input  logic [2:0]            s0_arprot,
  input  logic [3:0]            s0_arqos,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  output logic [DATA_W-1:0]     s0_rdata,
  output logic [1:0]            s0_rresp,
  output logic                  s0_rlast,
  output logic [ID_W-1:0]       s0_rid,
  // s1
  input  logic                  s1_awvalid,
  output logic                  s1_awready,
  input  logic [ADDR_W-1:0]     s1_awaddr,
  input  logic [ID_W-1:0]       s1_awid,
  input  logic [7:0]            s1_awlen,
  input  logic [2:0]            s1_awsize,
  input  logic [1:0]            s1_awburst,
  input  logic                  s1_awlock,
  input  logic [3:0]            s1_awcache,
  input  logic [2:0]            s1_awprot,
  input  logic [3:0]            s1_awqos,
  input  logic                  s1_wvalid,
  output logic                  s1_wready,
  input  logic [DATA_W-1:0]     s1_wdata,
  input  logic [DATA_W/8-1:0]   s1_wstrb,
  input  logic                  s1_wlast,
  output logic                  s1_bvalid,
  input  logic                  s1_bready,
  output logic [1:0]            s1_bresp,
  output logic [ID_W-1:0]       s1_bid,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  input  logic [ADDR_W-1:0]     s1_araddr,
  input  logic [ID_W-1:0]       s1_arid,
  input  logic [7:0]            s1_arlen,
  input  logic [2:0]            s1_arsize,
  input  logic [1:0]            s1_arburst,
  input  logic                  s1_arlock,
  input  logic [3:0]            s1_arcache,
  input  logic [2:0]            s1_arprot,
  input  logic [3:0]            s1_arqos,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  output logic [DATA_W-1:0]     s1_rdata,
  output logic [1:0]            s1_rresp,
  output logic                  s1_rlast,
  output logic [ID_W-1:0]       s1_rid,
  // downstream
  output logic                  out_awvalid,
  input  logic                  out_awready,
  output logic [ADDR_W-1:0]     out_awaddr,
  output logic [ID_W-1:0]       out_awid,
  output logic [7:0]            out_awlen,
  output logic [2:0]            out_awsize,
  output logic [1:0]            out_awburst,
  output logic                  out_awlock,
  output logic [3:0]            out_awcache,
  output logic [2:0]            out_awprot,
  output logic [3:0]            out_awqos,
  output logic                  out_wvalid,
  input  logic                  out_wready,
  output logic [DATA_W-1:0]     out_wdata,
  output logic [DATA_W/8-1:0]   out_wstrb,
  output logic                  out_wlast,
  input  logic                  out_bvalid,
  output logic                  out_bready,
  input  logic [1:0]            out_bresp,
  input  logic [ID_W-1:0]       out_bid,
  output logic                  out_arvalid,
  input  logic                  out_arready,
  output logic [ADDR_W-1:0]     out_araddr,
  output logic [ID_W-1:0]       out_arid,
  output logic [7:0]            out_arlen,
  output logic [2:0]            out_arsize,
  output logic [1:0]            out_arburst,
  output logic                  out_arlock,
  output logic [3:0]            out_arcache,
  output logic [2:0]            out_arprot,
  output logic [3:0]            out_arqos,
  input  logic                  out_rvalid,
  output logic                  out_rready,
  input  logic [DATA_W-1:0]     out_rdata,
  input  logic [1:0]            out_rresp,
  input  logic                  out_rlast,
  input  logic [ID_W-1:0]       out_rid
);

  rd_state_e r_rd_state;
  wr_state_e r_wr_state;

  logic w_rg;          // read grant index
  logic w_wg;          // write grant index
  logic w_rd_idle, w_rd_addr, w_rd_data;
  logic w_wr_idle, w_wr_addr, w_wr_data, w_wr_resp;
  logic w_rd_done, w_wr_done;

  assign w_rd_idle = (r_rd_state == R_IDLE);
  assign w_rd_addr = (r_rd_state == R_ADDR);
  assign w_rd_data = (r_rd_state == R_DATA);
  assign w_wr_idle = (r_wr_state == W_IDLE);
  assign w_wr_addr = (r_wr_state == W_ADDR);
  assign w_wr_data = (r_wr_state == W_DATA);
  assign w_wr_resp = (r_wr_state == W_RESP);

  assign w_rd_done = w_rd_data && out_rvalid && out_rready && out_rlast;
  assign w_wr_done = w_wr_resp && out_bvalid && out_bready;

  axi_rr_arb2 #(.RR_EN(RR_EN)) u_rd_arb (
    .clock     (clock),
    .reset     (reset),
    .i_req0    (s0_arvalid),
    .i_req1    (s1_arvalid),
    .i_capture (w_rd_idle),
    .i_done    (w_rd_done),
    .o_grant   (w_rg)
  );

  axi_rr_arb2 #(.RR_EN(RR_EN)) u_wr_arb (
    .clock     (clock),
    .reset     (reset),
    .i_req0    (s0_awvalid),
    .i_req1    (s1_awvalid),
    .i_capture (w_wr_idle),
    .i_done    (w_wr_done),
    .o_grant   (w_wg)
  );

  // Read sequencer
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_state <= R_IDLE;
    end else begin
      case (r_rd_state)
        R_IDLE: if (s0_arvalid || s1_arvalid) r_rd_state <= R_ADDR;
        R_ADDR: if (out_arvalid && out_arready) r_rd_state <= R_DATA;
        R_DATA: if (w_rd_done) r_rd_state <= R_IDLE;
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  // Write sequencer
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_state <= W_IDLE;
    end else begin
      case (r_wr_state)
        W_IDLE: if (s0_awvalid || s1_awvalid) r_wr_state <= W_ADDR;
        W_ADDR: if (out_awvalid && out_awready) r_wr_state <= W_DATA;
        W_DATA: if (out_wvalid && out_wready && out_wlast) r_wr_state <= W_RESP;
        W_RESP: if (w_wr_done) r_wr_state <= W_IDLE;
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  // AR channel: payload muxed freely, only valid/ready are state-gated.
  assign out_arvalid = w_rd_addr && (w_rg ? s1_arvalid : s0_arvalid);
  assign out_araddr  = w_rg ? s1_araddr  : s0_araddr;
  assign out_arid    = w_rg ? s1_arid    : s0_arid;
  assign out_arlen   = w_rg ? s1_arlen   : s0_arlen;
  assign out_arsize  = w_rg ? s1_arsize  : s0_arsize;
  assign out_arburst = w_rg ? s1_arburst : s0_arburst;
  assign out_arlock  = w_rg ? s1_arlock  : s0_arlock;
  assign out_arcache = w_rg ? s1_arcache : s0_arcache;
  assign out_arprot  = w_rg ? s1_arprot  : s0_arprot;
  assign out_arqos   = w_rg ? s1_arqos   : s0_arqos;
  assign s0_arready  = w_rd_addr && !w_rg && out_arready;
  assign s1_arready  = w_rd_addr &&  w_rg && out_arready;

  // R channel: a stray out_rvalid outside R_DATA stays pending downstream.
  assign out_rready  = w_rd_data && (w_rg ? s1_rready : s0_rready);
  assign s0_rvalid   = w_rd_data && !w_rg && out_rvalid;
  assign s1_rvalid   = w_rd_data &&  w_rg && out_rvalid;
  assign s0_rdata    = out_rdata;
  assign s1_rdata    = out_rdata;
  assign s0_rresp    = out_rresp;
  assign s1_rresp    = out_rresp;
  assign s0_rlast    = out_rlast;
  assign s1_rlast    = out_rlast;
  assign s0_rid      = out_rid;
  assign s1_rid      = out_rid;

  // AW channel
  assign out_awvalid = w_wr_addr && (w_wg ? s1_awvalid : s0_awvalid);
  assign out_awaddr  = w_wg ? s1_awaddr  : s0_awaddr;
  assign out_awid    = w_wg ? s1_awid    : s0_awid;
  assign out_awlen   = w_wg ? s1_awlen   : s0_awlen;
  assign out_awsize  = w_wg ? s1_awsize  : s0_awsize;
  assign out_awburst = w_wg ? s1_awburst : s0_awburst;
  assign out_awlock  = w_wg ? s1_awlock  : s0_awlock;
  assign out_awcache = w_wg ? s1_awcache : s0_awcache;
  assign out_awprot  = w_wg ? s1_awprot  : s0_awprot;
  assign out_awqos   = w_wg ? s1_awqos   : s0_awqos;
  assign s0_awready  = w_wr_addr && !w_wg && out_awready;
  assign s1_awready  = w_wr_addr &&  w_wg && out_awready;

  // W channel: beats held off until the address has been accepted.
  assign out_wvalid  = w_wr_data && (w_wg ? s1_wvalid : s0_wvalid);
  assign out_wdata   = w_wg ? s1_wdata : s0_wdata;
  assign out_wstrb   = w_wg ? s1_wstrb : s0_wstrb;
  assign out_wlast   = w_wg ? s1_wlast : s0_wlast;
  assign s0_wready   = w_wr_data && !w_wg && out_wready;
  assign s1_wready   = w_wr_data &&  w_wg && out_wready;

  // B channel
  assign out_bready  = w_wr_resp && (w_wg ? s1_bready : s0_bready);
  assign s0_bvalid   = w_wr_resp && !w_wg && out_bvalid;
  assign s1_bvalid   = w_wr_resp &&  w_wg && out_bvalid;
  assign s0_bresp    = out_bresp;
  assign s1_bresp    = out_bresp;
  assign s0_bid      = out_bid;
  assign s1_bid      = out_bid;

endmodule
